// File: rtl/arb_mux_n.sv
// arb_mux_n: N-input arbitrated multiplexer with a registered output stage.
//
// Each cycle one valid input port is granted, either round-robin (MODE=0)
// or lowest-index-first (MODE=1). The granted word is captured into the
// output register whenever that register is empty or draining this cycle.
//
// Ports
//   clk        sole clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   in         per-port data, SIZE bits x PORTS
//   in_valid   per-port data valid
//   in_ready   per-port accept strobe (at most one bit high)
//   out        registered selected data
//   out_valid  out holds an unconsumed word
//   out_port   index of the port that supplied out
//   out_ready  downstream accepts out this cycle
module arb_mux_n #(
    parameter int SIZE  = 8,
    parameter int PORTS = 4,
    parameter int MODE  = 0,
    localparam int PW   = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SIZE-1:0]  in [PORTS],
    input  logic [PORTS-1:0] in_valid,
    output logic [PORTS-1:0] in_ready,
    output logic [SIZE-1:0]  out,
    output logic             out_valid,
    output logic [PW-1:0]    out_port,
    input  logic             out_ready
);

    logic [SIZE-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   out_port_q, out_port_d;
    logic [PW-1:0]   last_grant_q, last_grant_d;

    logic            load;
    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand;
    logic [PORTS-1:0] grant;

    assign load = ~out_valid_q | out_ready;

    // Search order: round-robin starts one past the last winner and wraps
    // (PW-bit addition wraps mod PORTS since PORTS is a power of two), with
    // the last winner itself checked last. Fixed priority scans from 0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= PORTS; k++) begin
            if (MODE == 1) begin
                cand = PW'(k - 1);
            end else begin
                cand = last_grant_q + PW'(k);
            end
            if (!grant_any && in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant    = grant_any ? (PORTS'(1) << grant_idx) : '0;
    assign in_ready = load ? grant : '0;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        out_port_d   = out_port_q;
        last_grant_d = last_grant_q;
        if (load) begin
            if (grant_any) begin
                out_d        = in[grant_idx];
                out_port_d   = grant_idx;
                out_valid_d  = 1'b1;
                last_grant_d = grant_idx;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    // last_grant resets to PORTS-1 so the first round-robin search begins at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_port_q   <= '0;
            last_grant_q <= PW'(PORTS - 1);
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_port_q   <= out_port_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_port  = out_port_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: one round-robin and one fixed-priority instance share
// the same stimulus; a queue-free arithmetic model predicts both.
module tb_arb_mux_n;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] din [4];
    logic [3:0] in_valid;
    logic       out_ready;

    logic [3:0] d_rdy  [2];
    logic [7:0] d_out  [2];
    logic       d_vld  [2];
    logic [1:0] d_port [2];

    int checks = 0;
    int errors = 0;

    // model state per instance: 0 = round-robin, 1 = fixed priority
    int         m_last [2];
    logic [7:0] m_out  [2];
    logic       m_vld  [2];
    int         m_port [2];

    always #5 clk = ~clk;

    arb_mux_n #(.SIZE(8), .PORTS(4), .MODE(0)) u_rr (
        .clk(clk), .reset_n(reset_n), .in(din), .in_valid(in_valid),
        .in_ready(d_rdy[0]), .out(d_out[0]), .out_valid(d_vld[0]),
        .out_port(d_port[0]), .out_ready(out_ready));

    arb_mux_n #(.SIZE(8), .PORTS(4), .MODE(1)) u_fp (
        .clk(clk), .reset_n(reset_n), .in(din), .in_valid(in_valid),
        .in_ready(d_rdy[1]), .out(d_out[1]), .out_valid(d_vld[1]),
        .out_port(d_port[1]), .out_ready(out_ready));

    // Winner under the arbitration rules, -1 if nothing is valid.
    function automatic int pick(input int mode, input int last, input logic [3:0] v);
        int p;
        if (v == 4'b0000) return -1;
        for (int k = 0; k < 4; k++) begin
            p = (mode == 1) ? k : (last + 1 + k) % 4;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(input int j);
        int g;
        g = pick(j, m_last[j], in_valid);
        if ((!m_vld[j] || out_ready) && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < 2; j++) begin
                m_last[j] <= 3;
                m_out[j]  <= 8'h00;
                m_vld[j]  <= 1'b0;
                m_port[j] <= 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                int g;
                g = pick(j, m_last[j], in_valid);
                if (!m_vld[j] || out_ready) begin
                    if (g >= 0) begin
                        m_out[j]  <= din[g];
                        m_port[j] <= g;
                        m_vld[j]  <= 1'b1;
                        m_last[j] <= g;
                    end else begin
                        m_vld[j]  <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("model_valid[%0d]", j), 32'(d_vld[j]), 32'(m_vld[j]));
            chk($sformatf("model_out[%0d]", j), 32'(d_out[j]), 32'(m_out[j]));
            chk($sformatf("model_port[%0d]", j), 32'(d_port[j]), 32'(m_port[j]));
            chk($sformatf("model_rdy[%0d]", j), 32'(d_rdy[j]), 32'(exp_rdy(j)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        din[0] = 8'hA0; din[1] = 8'hA1; din[2] = 8'hA2; din[3] = 8'hA3;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1 reset_n = 1'b0;
        step(); step();
        chk("rst_valid", 32'(d_vld[0]), 0);
        chk("rst_out", 32'(d_out[0]), 32'h00);
        chk("rst_port", 32'(d_port[0]), 0);
        chk("rst_rdy", 32'(d_rdy[0]), 32'b0001);
        reset_n = 1'b1;

        // round-robin rotation from port 0
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rr_port_%0d", i), 32'(d_port[0]), 32'(seq[i]));
            chk($sformatf("rr_out_%0d", i), 32'(d_out[0]), 32'(8'hA0 + seq[i]));
            chk($sformatf("fp_port_%0d", i), 32'(d_port[1]), 0);
        end

        // backpressure: last_grant is 0
        out_ready = 1'b0;
        #1 chk("bp_rdy", 32'(d_rdy[0]), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_port_%0d", i), 32'(d_port[0]), 0);
            chk($sformatf("bp_out_%0d", i), 32'(d_out[0]), 32'hA0);
            chk($sformatf("bp_rdy_%0d", i), 32'(d_rdy[0]), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_port", 32'(d_port[0]), 1);

        // wrap: bring last_grant to 2, then 0101 must pick 0
        in_valid = 4'b0100;
        step();
        chk("wrap_setup_port", 32'(d_port[0]), 2);
        in_valid = 4'b0101;
        #1 chk("wrap_rdy", 32'(d_rdy[0]), 32'b0001);
        step();
        chk("wrap_port", 32'(d_port[0]), 0);
        in_valid = 4'b0100;
        step();
        chk("wrap_port2", 32'(d_port[0]), 2);

        // fixed priority
        in_valid = 4'b1111;
        step(); step();
        chk("fp_all", 32'(d_port[1]), 0);
        in_valid = 4'b1110;
        step();
        chk("fp_1110", 32'(d_port[1]), 1);
        chk("fp_1110_out", 32'(d_out[1]), 32'hA1);
        in_valid = 4'b0000;
        step();
        chk("fp_idle", 32'(d_vld[1]), 0);
        chk("rr_idle", 32'(d_vld[0]), 0);

        // async reset between edges while holding a word
        in_valid = 4'b1111;
        step();
        chk("ar_pre", 32'(d_vld[0]), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(d_vld[0]), 0);
        chk("ar_out", 32'(d_out[0]), 0);
        #1 reset_n = 1'b1;
        step();
        chk("ar_restart_port", 32'(d_port[0]), 0);
        chk("ar_restart_out", 32'(d_out[0]), 32'hA0);

        // mixed traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
